// File: rtl/reg_universal_shift_en_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_universal_shift_en_if
//  Purpose  : Bundles the control, data and status signals of the
//             universal shift register.
//  Ports    : EN, MODE, DP, SIN_R, SIN_L  - driven by the master
//             out, SOUT_R, SOUT_L,
//             shift_cnt, done              - driven by the register (slave)
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_universal_shift_en_if #(
  parameter int BITS = 8
);
  localparam int CW = $clog2(BITS + 1);

  logic            EN;
  logic [2:0]      MODE;
  logic [BITS-1:0] DP;
  logic            SIN_R;
  logic            SIN_L;
  logic [BITS-1:0] out;
  logic            SOUT_R;
  logic            SOUT_L;
  logic [CW-1:0]   shift_cnt;
  logic            done;

  modport master (
    output EN, MODE, DP, SIN_R, SIN_L,
    input  out, SOUT_R, SOUT_L, shift_cnt, done
  );

  modport slave (
    input  EN, MODE, DP, SIN_R, SIN_L,
    output out, SOUT_R, SOUT_L, shift_cnt, done
  );
endinterface
`default_nettype wire

// File: rtl/reg_universal_shift_en.sv
`default_nettype none
// ============================================================================
//  Module   : reg_universal_shift_en
//  Purpose  : BITS-wide universal shift register with enable: hold, load,
//             logical/arithmetic shifts, rotates and clear, plus a
//             saturating count of shifts since the last load/clear.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset
//             bus  - reg_universal_shift_en_if.slave (EN, MODE, DP, SIN_R,
//                    SIN_L in; out, SOUT_R, SOUT_L, shift_cnt, done out)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_universal_shift_en #(
  parameter int BITS = 8
) (
  input  wire                      clk,
  input  wire                      rst,
  reg_universal_shift_en_if.slave  bus
);
  localparam int CW = $clog2(BITS + 1);

  localparam logic [2:0] c_MODE_HOLD = 3'b000;
  localparam logic [2:0] c_MODE_LOAD = 3'b001;
  localparam logic [2:0] c_MODE_SHR  = 3'b010;
  localparam logic [2:0] c_MODE_SHL  = 3'b011;
  localparam logic [2:0] c_MODE_ROR  = 3'b100;
  localparam logic [2:0] c_MODE_ROL  = 3'b101;
  localparam logic [2:0] c_MODE_ASR  = 3'b110;
  localparam logic [2:0] c_MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] c_CNT_MAX = CW'(BITS);

  logic [BITS-1:0] r_state;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_inc;

  // Counter saturates at BITS so done stays asserted through extra shifts.
  assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_cnt   <= '0;
    end else if (bus.EN) begin
      case (bus.MODE)
        c_MODE_HOLD: begin
          r_state <= r_state;
          r_cnt   <= r_cnt;
        end
        c_MODE_LOAD: begin
          r_state <= bus.DP;
          r_cnt   <= '0;
        end
        c_MODE_SHR: begin
          r_state <= {bus.SIN_R, r_state[BITS-1:1]};
          r_cnt   <= w_cnt_inc;
        end
        c_MODE_SHL: begin
          r_state <= {r_state[BITS-2:0], bus.SIN_L};
          r_cnt   <= w_cnt_inc;
        end
        c_MODE_ROR: begin
          r_state <= {r_state[0], r_state[BITS-1:1]};
          r_cnt   <= w_cnt_inc;
        end
        c_MODE_ROL: begin
          r_state <= {r_state[BITS-2:0], r_state[BITS-1]};
          r_cnt   <= w_cnt_inc;
        end
        c_MODE_ASR: begin
          r_state <= {r_state[BITS-1], r_state[BITS-1:1]};
          r_cnt   <= w_cnt_inc;
        end
        c_MODE_CLR: begin
          r_state <= '0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= r_state;
          r_cnt   <= r_cnt;
        end
      endcase
    end
  end

  assign bus.out       = r_state;
  // Serial outputs show the bit the next right/left shift will push out.
  assign bus.SOUT_R    = r_state[0];
  assign bus.SOUT_L    = r_state[BITS-1];
  assign bus.shift_cnt = r_cnt;
  assign bus.done      = (r_cnt == c_CNT_MAX);
endmodule
`default_nettype wire

// File: doc/reg_universal_shift_en.md
REG_UNIVERSAL_SHIFT_EN -- requirements
Module: reg_universal_shift_en

Interface
REQ-001 The block SHALL have parameter BITS, default 8, register width (legal range 2..32).
REQ-002 The block SHALL have localparam CW = $clog2(BITS+1), shift-counter width (derived, not overridable).
REQ-003 Port: clk  input  1  rising-edge clock; the only clock.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: EN  input  1  enable; 0 freezes the register and the counter regardless of MODE.
REQ-006 Port: MODE  input  3  operation select, decoded per REQ-013.
REQ-007 Port: DP  input  BITS  parallel load data.
REQ-008 Port: SIN_R  input  1  serial input entering the MSB on a right shift.
REQ-009 Port: SIN_L  input  1  serial input entering the LSB on a left shift.
REQ-010 Port: out  output  BITS  current register state.
REQ-011 Port: SOUT_R / SOUT_L  output  1 each  state[0] / state[BITS-1], combinational from the current state.
REQ-012 Port: shift_cnt  output  CW  shifts/rotates performed since the last load/clear; done  output  1  high when shift_cnt == BITS.

Function
REQ-013 MODE decode (applies only when EN=1, takes effect at the rising edge):
 - 000 hold: state unchanged.
 - 001 load: state <= DP.
 - 010 logical shift right: state <= {SIN_R, state[BITS-1:1]}.
 - 011 shift left: state <= {state[BITS-2:0], SIN_L}.
 - 100 rotate right: state <= {state[0], state[BITS-1:1]}.
 - 101 rotate left: state <= {state[BITS-2:0], state[BITS-1]}.
 - 110 arithmetic shift right: state <= {state[BITS-1], state[BITS-1:1]}.
 - 111 clear: state <= 0.
REQ-014 Latency SHALL be one cycle: out reflects an operation immediately after the edge on which EN=1 was sampled; there is no combinational path from DP, MODE, or SIN_* to out.
REQ-015 With EN=0, state, shift_cnt, and done SHALL hold their values for any MODE, DP, or SIN_* value.
REQ-016 shift_cnt SHALL be set to 0 on load (001) or clear (111) with EN=1.
REQ-017 shift_cnt SHALL increment by 1 on modes 010–110 with EN=1, saturating at BITS; it never wraps to 0.
REQ-018 Hold (000) SHALL leave shift_cnt unchanged.
REQ-019 done SHALL be combinational from shift_cnt (done = shift_cnt == BITS); it SHALL stay high until the next load, clear, or reset.
REQ-020 After done is high, shift modes SHALL still operate on state; only the counter saturates.
REQ-021 SOUT_R and SOUT_L SHALL present the bit that the next right or left shift, respectively, will discard.
REQ-022 Rotates SHALL ignore SIN_R and SIN_L; mode 011 SHALL ignore SIN_R; modes 010 and 110 SHALL ignore SIN_L.
REQ-023 Undefined behaviour is prohibited: every MODE value is defined; all widths are exactly BITS or CW with no implicit truncation.

Reset
REQ-024 When rst=1 at a rising edge, state SHALL be 0 and shift_cnt SHALL be 0 after that edge; consequently out=0, SOUT_R=0, SOUT_L=0, done=0.
REQ-025 rst SHALL take priority over EN and MODE, including a reset asserted mid-sequence with shift_cnt between 1 and BITS-1.
REQ-026 The first operation after reset SHALL be accepted on the first edge with rst=0 and EN=1.
REQ-027 Before the first reset, output values are don't-care; the bench SHALL apply reset for at least 1 cycle.

Verification (BITS=8)
REQ-028 Load and hold: rst then EN=1 MODE=001 DP=8'hA5 -> out=8'hA5, shift_cnt=0. Next, EN=0 MODE=111 for 3 cycles -> out stays 8'hA5.
REQ-029 Shift directions: load 8'h81 -> SOUT_R=1, SOUT_L=1. MODE=010 SIN_R=0 -> 8'h40. MODE=011 SIN_L=1 -> 8'h81. MODE=110 -> 8'hC0.
REQ-030 Rotate and done: load 8'h01, then MODE=100 for 8 cycles -> out=8'h01, shift_cnt=8, done=1. A 9th rotate -> out=8'h80, shift_cnt stays 8.
REQ-031 Counter clear: after done=1, MODE=001 DP=8'h3C -> shift_cnt=0, done=0. MODE=111 -> out=0, shift_cnt=0.
REQ-032 Reset mid-operation: load 8'hFF, 3 shift-rights (shift_cnt=3), then rst=1 with EN=1 MODE=001 DP=8'h55 -> out=0, shift_cnt=0.
REQ-033 Serial-in fill: clear, then MODE=010 with SIN_R=1 for 8 cycles -> out=8'hFF, done=1.
